// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial CLA sequencer: slice width and FSM states.
package cla_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla.sv
// 8-bit carry-lookahead adder; every carry is a flat generate/propagate sum of products.
module cla
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] A,
    input  logic [BYTE_W-1:0] B,
    input  logic              Cin,
    output logic [BYTE_W-1:0] Sum,
    output logic              Cout
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;

    always_comb begin
        logic term;
        g = A & B;
        p = A ^ B;
        c = '0;
        c[0] = Cin;
        for (int unsigned i = 1; i <= BYTE_W; i++) begin
            // c[i] = Cin*p[0..i-1] + sum over k of g[k]*p[k+1..i-1]
            term = Cin;
            for (int unsigned j = 0; j < i; j++) begin
                term = term & p[j];
            end
            c[i] = term;
            for (int unsigned k = 0; k < i; k++) begin
                term = g[k];
                for (int unsigned j = k + 1; j < i; j++) begin
                    term = term & p[j];
                end
                c[i] = c[i] | term;
            end
        end
        Sum  = p ^ c[BYTE_W-1:0];
        Cout = c[BYTE_W];
    end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract: streams WORDS byte slices, LSB first, through one shared CLA.
module cla_mp_sequencer
    import cla_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BYTE_W*WORDS-1:0] req_A,
    input  logic [BYTE_W*WORDS-1:0] req_B,
    input  logic                  req_Cin,
    input  logic                  req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BYTE_W*WORDS-1:0] rsp_Sum,
    output logic                  rsp_Cout,
    output logic                  rsp_Ovf,
    output logic                  busy
);

    localparam int unsigned W     = BYTE_W * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      bx_reg;
    logic [BYTE_W-1:0] cla_a;
    logic [BYTE_W-1:0] cla_b;
    logic [BYTE_W-1:0] cla_sum;
    logic              cla_cout;

    assign cla_a = a_reg[BYTE_W*int'(idx) +: BYTE_W];
    assign cla_b = bx_reg[BYTE_W*int'(idx) +: BYTE_W];

    cla u_cla (
        .A    (cla_a),
        .B    (cla_b),
        .Cin  (carry),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            bx_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_Sum   <= '0;
            rsp_Cout  <= 1'b0;
            rsp_Ovf   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        // Subtraction is A + ~B + 1, so B is inverted once at capture.
                        a_reg     <= req_A;
                        bx_reg    <= req_sub ? ~req_B : req_B;
                        carry     <= req_sub | req_Cin;
                        idx       <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                RUN: begin
                    rsp_Sum[BYTE_W*int'(idx) +: BYTE_W] <= cla_sum;
                    carry <= cla_cout;
                    if (idx == LAST) begin
                        rsp_Cout  <= cla_cout;
                        rsp_Ovf   <= (a_reg[W-1] == bx_reg[W-1]) && (cla_sum[BYTE_W-1] != a_reg[W-1]);
                        idx       <= '0;
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Self-checking bench: directed corner cases plus random ops against an integer-arithmetic model.
module tb_cla_mp_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_A;
    logic [W-1:0] req_B;
    logic         req_Cin;
    logic         req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_Sum;
    logic         rsp_Cout;
    logic         rsp_Ovf;
    logic         busy;

    int unsigned n_cmp;
    int unsigned n_bad;

    cla_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A     (req_A),
        .req_B     (req_B),
        .req_Cin   (req_Cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_Sum   (rsp_Sum),
        .rsp_Cout  (rsp_Cout),
        .rsp_Ovf   (rsp_Ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on 64-bit values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] s, output logic co,
                         output logic ov);
        longint ua, ub, sa, sb, full, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            full = ua - ub;
            co   = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            co   = (full >= (64'sd1 <<< W));
            sres = sa + sb + longint'(cin);
        end
        s  = full[W-1:0];
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int unsigned hold);
        logic [W-1:0] es;
        logic         ec, eo;
        int unsigned  w;
        model(a, b, cin, sub, es, ec, eo);
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, ".req_ready"}, req_ready, 1);
        req_A = a; req_B = b; req_Cin = cin; req_sub = sub; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_A = $urandom; req_B = $urandom; req_Cin = 1'($urandom); req_sub = 1'($urandom);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, ".latency"}, w, WORDS);
        check({tag, ".sum"}, rsp_Sum, es);
        check({tag, ".cout"}, rsp_Cout, ec);
        check({tag, ".ovf"}, rsp_Ovf, eo);
        for (int unsigned h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, rsp_valid, 1);
            check({tag, ".hold_ready"}, req_ready, 0);
            check({tag, ".hold_sum"}, rsp_Sum, es);
            check({tag, ".hold_cout"}, rsp_Cout, ec);
            check({tag, ".hold_ovf"}, rsp_Ovf, eo);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".post_valid"}, rsp_valid, 0);
        check({tag, ".post_busy"}, busy, 0);
        check({tag, ".post_ready"}, req_ready, 1);
        check({tag, ".post_sum"}, rsp_Sum, es);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = 32'h7FFF_FFFF;
            3:       r = 32'h8000_0000;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        req_valid = 1'b1;
        req_A = 32'h1234_5678; req_B = 32'h1; req_Cin = 1'b0; req_sub = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.sum", rsp_Sum, 0);
        check("reset.cout", rsp_Cout, 0);
        check("reset.ovf", rsp_Ovf, 0);
        check("reset.busy", busy, 0);
        check("reset.req_ready", req_ready, 1);
        rst = 1'b0;
        req_valid = 1'b0;

        run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("t3", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("t4", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        run_op("t5", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 3);

        // Reset landing on the second RUN cycle discards the operation.
        req_A = 32'h1234_5678; req_B = 32'h1111_1111; req_Cin = 1'b1; req_sub = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6.rsp_valid", rsp_valid, 0);
        check("t6.busy", busy, 0);
        check("t6.req_ready", req_ready, 1);
        check("t6.sum", rsp_Sum, 0);
        check("t6.cout", rsp_Cout, 0);
        check("t6.ovf", rsp_Ovf, 0);
        run_op("t6b", 32'h55AA_55AA, 32'hAA55_AA55, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
